// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN sizing constants and pooled-size helper
package cnn_pkg;
  localparam int DATA_W = 12;
  localparam int FM_W = 24;
  localparam int POOL_W = FM_W / 2;
  function automatic int pool_size(input int fm_w);
    return fm_w / 2;
  endfunction
endpackage

// File: rtl/max_sel.sv
// max_sel: combinational signed maximum of two samples
module max_sel
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] max_o
);
  assign max_o = (a_i > b_i) ? a_i : b_i;
endmodule

// File: rtl/maxpool_relu.sv
// maxpool_relu: streaming 2x2 stride-2 max pooling over three channels; POOL_RELU_EN clamps negative inputs to 0
module maxpool_relu
  import cnn_pkg::*;
#(
  parameter int FM_W = cnn_pkg::FM_W,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] conv_out_1,
  input  logic signed [DATA_W-1:0] conv_out_2,
  input  logic signed [DATA_W-1:0] conv_out_3,
  output logic signed [DATA_W-1:0] max_value_1,
  output logic signed [DATA_W-1:0] max_value_2,
  output logic signed [DATA_W-1:0] max_value_3,
  output logic                     valid_out
);
  localparam int PW = pool_size(FM_W);
  localparam int CW = $clog2(FM_W);
  if (FM_W % 2 != 0) begin : g_odd
    $error("maxpool_relu: FM_W must be even");
  end
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [CW-2:0] idx;
  logic valid_q;
  logic signed [DATA_W-1:0] raw [3];
  assign raw[0] = conv_out_1;
  assign raw[1] = conv_out_2;
  assign raw[2] = conv_out_3;
  assign idx = col_q[CW-1:1];
  // raster position of the next accepted beat
  always_comb begin
    col_d = (col_q == CW'(FM_W - 1)) ? '0 : col_q + 1'b1;
    row_d = (col_q != CW'(FM_W - 1)) ? row_q : (row_q == CW'(FM_W - 1)) ? '0 : row_q + 1'b1;
  end
  // position counters advance on accepted beats; strobe follows an odd/odd beat by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in & col_q[0] & row_q[0];
      if (valid_in) begin
        col_q <= col_d;
        row_q <= row_d;
      end
    end
  end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic signed [DATA_W-1:0] x, pair, quad, hold_q, mv_q;
    logic signed [DATA_W-1:0] lb_q [PW];
`ifdef POOL_RELU_EN
    assign x = raw[c][DATA_W-1] ? '0 : raw[c];
`else
    assign x = raw[c];
`endif
    max_sel #(.DATA_W(DATA_W)) u_pair (.a_i(hold_q), .b_i(x), .max_o(pair));
    max_sel #(.DATA_W(DATA_W)) u_quad (.a_i(lb_q[idx]), .b_i(pair), .max_o(quad));
    // even column latches the left sample; odd column on an odd row emits the window max
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hold_q <= '0;
        mv_q <= '0;
      end else if (valid_in) begin
        if (!col_q[0]) hold_q <= x;
        else if (row_q[0]) mv_q <= quad;
      end
    end
    // top-row pair maxima wait here for the row below; contents need no reset
    always_ff @(posedge clk) begin
      if (valid_in & col_q[0] & ~row_q[0]) lb_q[idx] <= pair;
    end
  end
  assign max_value_1 = g_ch[0].mv_q;
  assign max_value_2 = g_ch[1].mv_q;
  assign max_value_3 = g_ch[2].mv_q;
  assign valid_out = valid_q;
endmodule

// File: tb/tb_maxpool_relu.sv
// tb_maxpool_relu: randomized frames checked against a whole-image 2x2 pooling model
module tb_maxpool_relu;
  localparam int FM = 24;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic signed [11:0] conv_out_1 = '0, conv_out_2 = '0, conv_out_3 = '0;
  logic signed [11:0] max_value_1, max_value_2, max_value_3;
  logic valid_out;
  logic signed [11:0] mv [3];
  int n_tests = 0;
  int n_fail = 0;
  int img [3][FM][FM];
  int obs [3][$];
  int pos = 0;
  bit exp_v = 1'b0;
  logic signed [11:0] exp_mv [3] = '{default: '0};

  maxpool_relu dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .conv_out_1(conv_out_1), .conv_out_2(conv_out_2), .conv_out_3(conv_out_3),
    .max_value_1(max_value_1), .max_value_2(max_value_2), .max_value_3(max_value_3),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;
  assign mv[0] = max_value_1;
  assign mv[1] = max_value_2;
  assign mv[2] = max_value_3;

  function automatic int relu(input int v);
`ifdef POOL_RELU_EN
    return v < 0 ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int win_max(input int ch, input int r, input int c);
    int m;
    m = relu(img[ch][r-1][c-1]);
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (relu(img[ch][r-dr][c-dc]) > m) m = relu(img[ch][r-dr][c-dc]);
    return m;
  endfunction

  function automatic int rnd12();
    return int'($urandom_range(4095)) - 2048;
  endfunction

  task automatic fill(input bit neg3);
    for (int r = 0; r < FM; r++)
      for (int c = 0; c < FM; c++) begin
        img[0][r][c] = r * FM + c;
        img[1][r][c] = rnd12();
        img[2][r][c] = neg3 ? -(r * FM + c) : rnd12();
      end
  endtask

  task automatic clear_obs();
    for (int ch = 0; ch < 3; ch++) obs[ch].delete();
  endtask

  task automatic model_reset();
    pos = 0;
    exp_v = 1'b0;
    for (int ch = 0; ch < 3; ch++) exp_mv[ch] = '0;
  endtask

  task automatic step(input bit v);
    int r, c;
    @(negedge clk);
    n_tests++;
    if (valid_out !== exp_v) begin
      n_fail++;
      $display("FAIL valid_out pos=%0d got %b expected %b", pos, valid_out, exp_v);
    end
    for (int ch = 0; ch < 3; ch++) begin
      n_tests++;
      if (mv[ch] !== exp_mv[ch]) begin
        n_fail++;
        $display("FAIL max_value_%0d pos=%0d got %0d expected %0d", ch + 1, pos, mv[ch], exp_mv[ch]);
      end
    end
    if (exp_v && valid_out)
      for (int ch = 0; ch < 3; ch++) obs[ch].push_back(int'(mv[ch]));
    valid_in = v;
    if (v) begin
      r = pos / FM;
      c = pos % FM;
      conv_out_1 = 12'(img[0][r][c]);
      conv_out_2 = 12'(img[1][r][c]);
      conv_out_3 = 12'(img[2][r][c]);
      exp_v = (r % 2 == 1) && (c % 2 == 1);
      if (exp_v)
        for (int ch = 0; ch < 3; ch++) exp_mv[ch] = 12'(win_max(ch, r, c));
      pos = (pos + 1) % (FM * FM);
    end else begin
      conv_out_1 = 12'(rnd12());
      conv_out_2 = 12'(rnd12());
      conv_out_3 = 12'(rnd12());
      exp_v = 1'b0;
    end
  endtask

  task automatic play_frame(input int gap);
    for (int i = 0; i < FM * FM; i++) begin
      step(1'b1);
      repeat (gap) step(1'b0);
    end
  endtask

  task automatic check_frame(input string name, input int n, input int first0, input int last0);
    n_tests++;
    if (obs[0].size() != n) begin
      n_fail++;
      $display("FAIL %s strobe count got %0d expected %0d", name, obs[0].size(), n);
    end
    n_tests++;
    if (obs[0].size() == 0 || obs[0][0] != first0) begin
      n_fail++;
      $display("FAIL %s first ch1 got %0d expected %0d", name, obs[0].size() ? obs[0][0] : -99999, first0);
    end
    n_tests++;
    if (obs[0].size() == 0 || obs[0][obs[0].size()-1] != last0) begin
      n_fail++;
      $display("FAIL %s last ch1 got %0d expected %0d", name, obs[0].size() ? obs[0][obs[0].size()-1] : -99999, last0);
    end
  endtask

  task automatic check_reset_state(input string name);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s valid_out got %b expected 0", name, valid_out);
    end
    for (int ch = 0; ch < 3; ch++) begin
      n_tests++;
      if (mv[ch] !== 12'sd0) begin
        n_fail++;
        $display("FAIL %s max_value_%0d got %0d expected 0", name, ch + 1, mv[ch]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      valid_in = 1'($urandom);
      conv_out_1 = 12'(rnd12());
      conv_out_2 = 12'(rnd12());
      conv_out_3 = 12'(rnd12());
    end
    @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    valid_in = 1'b0;
    model_reset();
  endtask

  task automatic test_ramp();
    fill(1'b0);
    clear_obs();
    play_frame(0);
    step(1'b0);
    check_frame("ramp", 144, 25, 575);
  endtask

  task automatic test_idle_gaps();
    fill(1'b0);
    clear_obs();
    play_frame(3);
    step(1'b0);
    check_frame("idle_gaps", 144, 25, 575);
  endtask

  task automatic test_negative_window();
    fill(1'b0);
    img[1][0][0] = -5;
    img[1][0][1] = -3;
    img[1][1][0] = -7;
    img[1][1][1] = -9;
    clear_obs();
    play_frame(0);
    step(1'b0);
    n_tests++;
    if (obs[1].size() == 0 || obs[1][0] != relu(-3)) begin
      n_fail++;
      $display("FAIL negative_window ch2 got %0d expected %0d", obs[1].size() ? obs[1][0] : -99999, relu(-3));
    end
  endtask

  task automatic test_extremes();
    fill(1'b0);
    img[2][0][0] = 2047;
    img[2][0][1] = -2048;
    img[2][1][0] = 0;
    img[2][1][1] = 1;
    clear_obs();
    play_frame(0);
    step(1'b0);
    n_tests++;
    if (obs[2].size() == 0 || obs[2][0] != 2047) begin
      n_fail++;
      $display("FAIL extremes ch3 got %0d expected 2047", obs[2].size() ? obs[2][0] : -99999);
    end
  endtask

  task automatic test_mid_reset();
    fill(1'b0);
    for (int i = 0; i < 100; i++) step(1'b1);
    step(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    valid_in = 1'b1;
    @(negedge clk);
    check_reset_state("mid_reset");
    rst_n = 1'b1;
    valid_in = 1'b0;
    model_reset();
    fill(1'b0);
    clear_obs();
    play_frame(0);
    step(1'b0);
    check_frame("mid_reset", 144, 25, 575);
  endtask

  task automatic test_back_to_back();
    fill(1'b0);
    clear_obs();
    play_frame(0);
    fill(1'b1);
    play_frame(0);
    step(1'b0);
    check_frame("back_to_back", 288, 25, 575);
    n_tests++;
    if (obs[2].size() != 288 || obs[2][144] != 0) begin
      n_fail++;
      $display("FAIL back_to_back frame2 first ch3 got %0d expected 0", obs[2].size() > 144 ? obs[2][144] : -99999);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_idle_gaps();
    test_negative_window();
    test_extremes();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/maxpool_relu.md
MAXPOOL_RELU -- requirements
Module: maxpool_relu

Interface
REQ-001 SHALL have parameter FM_W, default 24, meaning feature-map width and height in samples (square map).
REQ-002 SHALL have parameter DATA_W, default 12, meaning signed sample width per channel.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port valid_in  input  1  qualifies one conv sample beat on all three channels.
REQ-006 SHALL have ports conv_out_1, conv_out_2, conv_out_3  input  DATA_W signed  per-channel conv results, raster order.
REQ-007 SHALL have ports max_value_1, max_value_2, max_value_3  output  DATA_W signed  pooled result per channel.
REQ-008 SHALL have port valid_out  output  1  one-cycle strobe qualifying max_value_1..3.

Function
REQ-009 SHALL count accepted beats with column counter col (0..FM_W-1) and row counter row (0..FM_W-1); both advance only when valid_in=1.
REQ-010 SHALL wrap col to 0 after FM_W-1 and increment row; after row=FM_W-1, col=FM_W-1, both wrap to 0 (next frame, no idle cycle needed).
REQ-011 SHALL, on an even-col beat, store the sample in a per-channel hold register.
REQ-012 SHALL, on an odd-col beat of an even row, write max(hold, sample) into per-channel line buffer entry col>>1 (FM_W/2 entries).
REQ-013 SHALL, on an odd-col beat of an odd row, register max(buffer[col>>1], hold, sample) to max_value_n and assert valid_out in the next cycle.
REQ-014 SHALL compare as two's-complement signed; ties select either (equal values).
REQ-015 SHALL have latency exactly 1 cycle from the completing input beat to valid_out.
REQ-016 SHALL produce (FM_W/2)^2 = 144 strobes per frame with default FM_W, in raster order of the pooled map.
REQ-017 SHALL hold max_value_n stable when valid_out=0; valid_out SHALL be high for one cycle per output.
REQ-018 SHALL tolerate arbitrary idle cycles (valid_in=0) between beats without changing state.
REQ-019 SHALL have no back-pressure; every valid_in beat is consumed.

Reset
REQ-020 SHALL, while rst_n=0 at a clock edge, clear col, row, hold registers, max_value_1..3 to 0 and valid_out to 0.
REQ-021 SHALL leave line-buffer contents unreset; they are rewritten before use in every frame.
REQ-022 SHALL, on reset mid-frame, discard the partial frame; the first beat after release is treated as row 0, col 0.

Configuration
REQ-023 SHALL, with macro POOL_RELU_EN defined, clamp each input sample to 0 when negative before any comparison, so outputs are always >= 0.
REQ-024 SHALL, without POOL_RELU_EN, pool raw signed samples; negative maxima pass through unchanged.

Structure
REQ-025 SHALL take DATA_W, FM_W defaults and the pooled-size constant FM_W/2 from shared package cnn_pkg.
REQ-026 SHALL instantiate sub-module max_sel (two signed DATA_W inputs, combinational max output) for all comparisons.
REQ-027 SHALL require FM_W even; an odd value is a compile-time error.

Verification
REQ-028 Frame with channel 1 sample = row*24+col (all positive), continuous valid -> 144 strobes; first max_value_1 = 25, last = 575.
REQ-029 2x2 window {-5, -3, -7, -9} on channel 2 at pooled (0,0) -> max_value_2 = -3 without POOL_RELU_EN, 0 with it.
REQ-030 Same frame as REQ-028 with valid_in low for 3 idle cycles between every beat -> identical 144 outputs, each strobe exactly 1 cycle after the completing beat.
REQ-031 rst_n low for one cycle after 100 beats, then a full frame -> no strobe from the aborted frame; 144 correct outputs from the new one.
REQ-032 Two back-to-back frames, second with values negated on channel 3 -> frame-2 first output = -0 (i.e. 0 for window {0,-1,-24,-25}), no cross-frame contamination.
REQ-033 Channel 3 window {2047, -2048, 0, 1} -> max_value_3 = 2047 (signed extremes).
